// File: rtl/n64_vinfo_ctrl.sv
// n64_vinfo_ctrl: tracks the N64 4-phase video bus, measures lines per field
// to derive PAL/NTSC and interlace flags, latches the user deblur switches at
// field boundaries and packs everything into deblurparams_o.
module n64_vinfo_ctrl #(
    parameter int                    LINE_CNT_W  = 10,
    parameter logic [LINE_CNT_W-1:0] PAL_LINE_TH = LINE_CNT_W'(288),
    parameter int                    IL_HYST     = 2
) (
    input  logic       VCLK,
    input  logic       RST,
    input  logic       nDSYNC,
    input  logic [3:0] D_i,
    input  logic       nForceDeBlur_i,
    input  logic       nDeBlurMan_i,
    output logic [5:0] deblurparams_o,
    output logic       new_frame_o,
    output logic       vinfo_valid_o,
    output logic       desync_o
);

    localparam logic [1:0] HYST_MAX = 2'(IL_HYST);

    logic [1:0]            data_cnt;
    logic                  sync_seen;
    logic [3:0]            prev_sync;
    logic [LINE_CNT_W-1:0] line_cnt;
    logic [LINE_CNT_W-1:0] prev_field_cnt;
    logic                  field_seen;
    logic [1:0]            hyst;
    logic                  vmode;
    logic                  n64_480i;
    logic                  force_q;
    logic                  man_q;

    logic       sync_ph;
    logic       hs_fall;
    logic       vs_fall;
    logic [1:0] hyst_up;
    logic [1:0] hyst_dn;

    // Sync-phase edge detection against the last sync nibble seen on the bus
    always_comb begin
        sync_ph = ~nDSYNC;
        hs_fall = sync_ph & prev_sync[1] & ~D_i[1];
        vs_fall = sync_ph & prev_sync[3] & ~D_i[3];
        hyst_up = (hyst == HYST_MAX) ? HYST_MAX : hyst + 2'd1;
        hyst_dn = (hyst == 2'd0) ? 2'd0 : hyst - 2'd1;
    end

    // Bus phase counter; a sync arriving off-phase (after the first one) is sticky-flagged
    always_ff @(posedge VCLK) begin
        if (RST) begin
            data_cnt  <= 2'b00;
            sync_seen <= 1'b0;
            desync_o  <= 1'b0;
        end else if (sync_ph) begin
            data_cnt  <= 2'b01;
            sync_seen <= 1'b1;
            if (sync_seen && (data_cnt != 2'b00))
                desync_o <= 1'b1;
        end else begin
            data_cnt <= data_cnt + 2'd1;
        end
    end

    // Previous sync sample and saturating line counter; the field boundary wins over HSYNC
    always_ff @(posedge VCLK) begin
        if (RST) begin
            prev_sync <= 4'hF;
            line_cnt  <= '0;
        end else if (sync_ph) begin
            prev_sync <= D_i;
            if (vs_fall)
                line_cnt <= '0;
            else if (hs_fall && (line_cnt != '1))
                line_cnt <= line_cnt + 1'b1;
        end
    end

    // Field-boundary bookkeeping: mode detection, interlace hysteresis, switch latching
    always_ff @(posedge VCLK) begin
        if (RST) begin
            prev_field_cnt <= '0;
            field_seen     <= 1'b0;
            vinfo_valid_o  <= 1'b0;
            vmode          <= 1'b0;
            n64_480i       <= 1'b0;
            hyst           <= 2'd0;
            force_q        <= 1'b1;
            man_q          <= 1'b1;
            new_frame_o    <= 1'b0;
        end else begin
            new_frame_o <= vs_fall;
            if (vs_fall) begin
                force_q        <= nForceDeBlur_i;
                man_q          <= nDeBlurMan_i;
                prev_field_cnt <= line_cnt;
                field_seen     <= 1'b1;
                // The first boundary only primes prev_field_cnt; nothing to compare yet
                if (field_seen) begin
                    vinfo_valid_o <= 1'b1;
                    vmode         <= (line_cnt > PAL_LINE_TH);
                    if (line_cnt != prev_field_cnt) begin
                        hyst <= hyst_up;
                        if (hyst_up == HYST_MAX)
                            n64_480i <= 1'b1;
                    end else begin
                        hyst <= hyst_dn;
                        if (hyst_dn == 2'd0)
                            n64_480i <= 1'b0;
                    end
                end
            end
        end
    end

    assign deblurparams_o = {data_cnt, vmode, n64_480i, force_q, man_q};

endmodule

// File: doc/n64_vinfo_ctrl.md
Name: n64_vinfo_ctrl

Overview:
- Control and configuration block for the deblur estimator and the other per-pixel datapath stages.
- Tracks the N64 4-phase video bus (sync, R, G, B) and produces the data_cnt phase.
- Measures lines per field to derive vmode (PAL/NTSC) and n64_480i (interlaced).
- Latches the user deblur switches at frame boundaries and packs everything into the 6-bit deblurparams vector.

Parameters:
- PAL_LINE_TH, 10'd288, field line count above which vmode=1 (PAL).
- LINE_CNT_W, 10, width of line counter (saturating).
- IL_HYST, 2, consecutive fields needed to set or clear n64_480i (1..3).

Ports:
- VCLK  in  1  video clock, all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- nDSYNC  in  1  low = sync phase on bus.
- D_i  in  4  bus low nibble: [3]=nVSYNC, [2]=nCLAMP, [1]=nHSYNC, [0]=nCSYNC; valid only when nDSYNC=0.
- nForceDeBlur_i  in  1  0 = manual deblur mode.
- nDeBlurMan_i  in  1  manual setting (0 = deblur on).
- deblurparams_o  out  6  {data_cnt[1:0], vmode, n64_480i, nForceDeBlur, nDeBlurMan}.
- new_frame_o  out  1  1-cycle pulse at detected nVSYNC falling edge.
- vinfo_valid_o  out  1  1 once at least one complete field has been measured.
- desync_o  out  1  sticky phase error flag, cleared by RST.

Behaviour:
- Reset values: data_cnt=00, vmode=0, n64_480i=0, latched nForceDeBlur=1, nDeBlurMan=1, new_frame_o=0, vinfo_valid_o=0, desync_o=0, line counter=0, previous sync sample=4'hF, hysteresis counter=0.
- Phase counter:
  - nDSYNC=0: data_cnt<=01.
  - Otherwise: data_cnt<=data_cnt+1, wrapping 11->00.
  - nDSYNC=0 while data_cnt!=00 (current value, ignoring reset/first sync after reset): desync_o<=1. Phase still re-aligns to 01.
  - The first nDSYNC low after RST never sets desync_o.
- Sync edge detection: only in cycles with nDSYNC=0. Compare D_i against the registered previous sync sample, then update that sample.
  - nHSYNC falling edge (prev[1]=1, D_i[1]=0): line_cnt+1, saturating at all-ones.
  - nVSYNC falling edge (prev[3]=1, D_i[3]=0) is the field boundary. In the same cycle:
    - new_frame_o<=1.
    - vmode<=(line_cnt>PAL_LINE_TH).
    - Latch nForceDeBlur_i and nDeBlurMan_i.
    - Compare line_cnt with prev_field_cnt:
      - Mismatch: hyst<=hyst+1, saturating at IL_HYST; reaching IL_HYST sets n64_480i=1.
      - Match: hyst<=hyst-1, floor 0; reaching 0 clears n64_480i.
    - prev_field_cnt<=line_cnt.
    - line_cnt<=0. An HSYNC edge in the same cycle is not counted; this cycle has priority.
    - vinfo_valid_o<=1 from the second field boundary after reset; the first boundary only primes prev_field_cnt.
  - Before vinfo_valid_o is set, vmode and n64_480i keep their reset values.
- new_frame_o is high for exactly one VCLK cycle per boundary.
- Output packing: deblurparams_o[5:4]=data_cnt (registered, same cycle as bus data). Bits [3:0] change only on the new_frame_o cycle, so downstream settings stay stable within a field.
- Switches: changes on nForceDeBlur_i/nDeBlurMan_i between boundaries have no effect on outputs until the next boundary.
- Reset mid-field: all state returns to reset values on the next edge. Measurement restarts and vinfo_valid_o needs two boundaries again.
- Latency: data_cnt is valid 1 cycle after sync phase. Mode bits update 1 cycle after the VCLK edge sampling the nVSYNC fall.

Test Plan:
- Repeating 4-cycle bus (nDSYNC low every 4th cycle), sync nibble F -> data_cnt sequence 01,10,11,00 in lockstep; desync_o stays 0.
- Insert an nDSYNC low after only 2 data cycles -> desync_o=1 and stays 1; data_cnt re-aligns to 01 the next cycle; RST clears the flag.
- Three fields of 313 HSYNC falls each -> after the 2nd boundary vinfo_valid_o=1, vmode=1, n64_480i=0; with 263 lines -> vmode=0.
- Alternating fields of 262/263 lines, IL_HYST=2 -> n64_480i=1 at the 3rd boundary (2 mismatches); then constant 263 -> cleared after 2 matching fields.
- Toggle nDeBlurMan_i 1->0 mid-field -> deblurparams_o[0] stays 1 until the new_frame_o cycle, then 0; new_frame_o is a single-cycle pulse.
- Assert RST mid-field, then release -> all outputs at reset values next cycle; vinfo_valid_o returns only after two new nVSYNC falls.
